// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state codes, group tags and frame geometry for display_capture
package display_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PE   = 3'd1,
      S_3X3  = 3'd2,
      S_2X2  = 3'd3,
      S_DONE = 3'd4
   } cap_state_e;

   localparam logic [2:0] TAG_PE  = 3'd1;
   localparam logic [2:0] TAG_3X3 = 3'd2;
   localparam logic [2:0] TAG_2X2 = 3'd3;

   localparam int         BEATS_PER_GROUP = 4;
   localparam logic [1:0] LAST_BEAT       = 2'(BEATS_PER_GROUP - 1);

endpackage

// File: rtl/display_capture_group.sv
// rtl/display_capture_group.sv - one 4-byte shadow group (c11, c12, c21, c22) with write-index decode
module capture_group
   import display_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_i,
   input  logic       wr_en_i,
   input  logic [1:0] wr_idx_i,
   input  logic [7:0] wr_data_i,
   output logic [7:0] c11_o,
   output logic [7:0] c12_o,
   output logic [7:0] c21_o,
   output logic [7:0] c22_o
);

   logic [7:0] byte_q [BEATS_PER_GROUP];
   logic [7:0] byte_d [BEATS_PER_GROUP];

   // Clear wins over write so an aborted frame leaves nothing behind
   always_comb begin
      byte_d = byte_q;
      if (clr_i) begin
         for (int i = 0; i < BEATS_PER_GROUP; i++) begin
            byte_d[i] = 8'd0;
         end
      end else if (wr_en_i) begin
         byte_d[wr_idx_i] = wr_data_i;
      end
   end

   // Shadow byte storage
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < BEATS_PER_GROUP; i++) begin
            byte_q[i] <= 8'd0;
         end
      end else begin
         byte_q <= byte_d;
      end
   end

   assign c11_o = byte_q[0];
   assign c12_o = byte_q[1];
   assign c21_o = byte_q[2];
   assign c22_o = byte_q[3];

endmodule

// File: rtl/display_capture.sv
// rtl/display_capture.sv - reassembles 12-beat PE/3x3/2x2 frames; DISPLAY_CAPTURE_ERR_EN enables sticky tag-error abort
module display_capture
   import display_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       run_capture,
   input  logic       display_valid_i,
   input  logic [7:0] display_result_i,
   input  logic [2:0] state_display_i,
   output logic [7:0] c11_PE,
   output logic [7:0] c12_PE,
   output logic [7:0] c21_PE,
   output logic [7:0] c22_PE,
   output logic [7:0] c11_3x3,
   output logic [7:0] c12_3x3,
   output logic [7:0] c21_3x3,
   output logic [7:0] c22_3x3,
   output logic [7:0] c11_2x2,
   output logic [7:0] c12_2x2,
   output logic [7:0] c21_2x2,
   output logic [7:0] c22_2x2,
   output logic       frame_done_o,
   output logic       error_o,
   output logic [2:0] capture_state_o
);

   cap_state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       frame_done_q, frame_done_d;
   logic       error_q, error_d;
   logic [7:0] out_q [12];
   logic [7:0] out_d [12];

   logic [2:0] exp_tag;
   logic [1:0] wr_idx;
   logic [2:0] wr_en;
   logic       shadow_clr;
   logic [7:0] pe_b [4];
   logic [7:0] g3_b [4];
   logic [7:0] g2_b [4];

   capture_group u_grp_pe (
      .clk(clk), .reset(reset), .clr_i(shadow_clr), .wr_en_i(wr_en[0]),
      .wr_idx_i(wr_idx), .wr_data_i(display_result_i),
      .c11_o(pe_b[0]), .c12_o(pe_b[1]), .c21_o(pe_b[2]), .c22_o(pe_b[3])
   );

   capture_group u_grp_3x3 (
      .clk(clk), .reset(reset), .clr_i(shadow_clr), .wr_en_i(wr_en[1]),
      .wr_idx_i(wr_idx), .wr_data_i(display_result_i),
      .c11_o(g3_b[0]), .c12_o(g3_b[1]), .c21_o(g3_b[2]), .c22_o(g3_b[3])
   );

   capture_group u_grp_2x2 (
      .clk(clk), .reset(reset), .clr_i(shadow_clr), .wr_en_i(wr_en[2]),
      .wr_idx_i(wr_idx), .wr_data_i(display_result_i),
      .c11_o(g2_b[0]), .c12_o(g2_b[1]), .c21_o(g2_b[2]), .c22_o(g2_b[3])
   );

   // Next state, beat counter, shadow writes and frame commit
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      error_d      = error_q;
      out_d        = out_q;
      shadow_clr   = 1'b0;
      wr_en        = 3'b000;
      case (state_q)
         S_3X3:   exp_tag = TAG_3X3;
         S_2X2:   exp_tag = TAG_2X2;
         default: exp_tag = TAG_PE;
      endcase
      // A frame always starts at c11, whatever the counter last held
      wr_idx = (state_q == S_IDLE || state_q == S_DONE) ? 2'd0 : cnt_q;

      if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end

      if (!run_capture) begin
         if (state_q != S_IDLE) begin
            state_d    = S_IDLE;
            cnt_d      = 2'd0;
            shadow_clr = 1'b1;
         end
      end else if (display_valid_i) begin
         if (state_display_i == exp_tag) begin
            cnt_d = cnt_q + 2'd1;
            case (state_q)
               S_IDLE, S_DONE: begin
                  wr_en[0] = 1'b1;
                  cnt_d    = 2'd1;
                  state_d  = S_PE;
               end
               S_PE: begin
                  wr_en[0] = 1'b1;
                  if (cnt_q == LAST_BEAT) state_d = S_3X3;
               end
               S_3X3: begin
                  wr_en[1] = 1'b1;
                  if (cnt_q == LAST_BEAT) state_d = S_2X2;
               end
               S_2X2: begin
                  wr_en[2] = 1'b1;
                  if (cnt_q == LAST_BEAT) begin
                     // Final beat bypasses its shadow slot so all 12 outputs move on this edge
                     state_d      = S_DONE;
                     frame_done_d = 1'b1;
                     for (int i = 0; i < 4; i++) begin
                        out_d[i]     = pe_b[i];
                        out_d[4 + i] = g3_b[i];
                     end
                     for (int i = 0; i < 3; i++) begin
                        out_d[8 + i] = g2_b[i];
                     end
                     out_d[11] = display_result_i;
                  end
               end
               default: ;
            endcase
         end else begin
`ifdef DISPLAY_CAPTURE_ERR_EN
            error_d    = 1'b1;
            state_d    = S_IDLE;
            cnt_d      = 2'd0;
            shadow_clr = 1'b1;
`endif
         end
      end
   end

   // State, counter, committed outputs and flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
         for (int i = 0; i < 12; i++) begin
            out_q[i] <= 8'd0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         error_q      <= error_d;
         out_q        <= out_d;
      end
   end

   assign c11_PE  = out_q[0];
   assign c12_PE  = out_q[1];
   assign c21_PE  = out_q[2];
   assign c22_PE  = out_q[3];
   assign c11_3x3 = out_q[4];
   assign c12_3x3 = out_q[5];
   assign c21_3x3 = out_q[6];
   assign c22_3x3 = out_q[7];
   assign c11_2x2 = out_q[8];
   assign c12_2x2 = out_q[9];
   assign c21_2x2 = out_q[10];
   assign c22_2x2 = out_q[11];

   assign frame_done_o    = frame_done_q;
   assign error_o         = error_q;
   assign capture_state_o = state_q;

endmodule

// File: tb/tb_display_capture.sv
// tb/tb_display_capture.sv - directed scoreboard bench for display_capture
module tb_display_capture;
   import display_pkg::*;

   typedef logic [11:0][7:0] frame_t;

`ifdef DISPLAY_CAPTURE_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       run_capture;
   logic       display_valid_i;
   logic [7:0] display_result_i;
   logic [2:0] state_display_i;
   logic [7:0] c11_PE, c12_PE, c21_PE, c22_PE;
   logic [7:0] c11_3x3, c12_3x3, c21_3x3, c22_3x3;
   logic [7:0] c11_2x2, c12_2x2, c21_2x2, c22_2x2;
   logic       frame_done_o;
   logic       error_o;
   logic [2:0] capture_state_o;

   frame_t obs;
   frame_t exp_q [$];
   int     vectors     = 0;
   int     miscompares = 0;
   int     done_count  = 0;

   assign obs = {c22_2x2, c21_2x2, c12_2x2, c11_2x2,
                 c22_3x3, c21_3x3, c12_3x3, c11_3x3,
                 c22_PE,  c21_PE,  c12_PE,  c11_PE};

   display_capture dut (
      .clk(clk), .reset(reset), .run_capture(run_capture),
      .display_valid_i(display_valid_i), .display_result_i(display_result_i),
      .state_display_i(state_display_i),
      .c11_PE(c11_PE), .c12_PE(c12_PE), .c21_PE(c21_PE), .c22_PE(c22_PE),
      .c11_3x3(c11_3x3), .c12_3x3(c12_3x3), .c21_3x3(c21_3x3), .c22_3x3(c22_3x3),
      .c11_2x2(c11_2x2), .c12_2x2(c12_2x2), .c21_2x2(c21_2x2), .c22_2x2(c22_2x2),
      .frame_done_o(frame_done_o), .error_o(error_o), .capture_state_o(capture_state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] o, input logic [95:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic frame_t mk(input logic [7:0] base);
      frame_t f;
      for (int i = 0; i < 12; i++) f[i] = base + 8'(i);
      return f;
   endfunction

   function automatic logic [2:0] tag_of(input int i);
      return (i < 4) ? TAG_PE : (i < 8) ? TAG_3X3 : TAG_2X2;
   endfunction

   // One clock; every done pulse is matched against the scoreboard
   task automatic tick();
      frame_t e;
      @(posedge clk);
      #1;
      if (frame_done_o === 1'b1) begin
         done_count++;
         check("done_expected", 96'(exp_q.size() != 0), 96'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame", obs, e);
         end
      end
   endtask

   task automatic beat(input logic [7:0] data, input logic [2:0] tag);
      display_valid_i  = 1'b1;
      display_result_i = data;
      state_display_i  = tag;
      tick();
      display_valid_i  = 1'b0;
   endtask

   task automatic send_beats(input logic [7:0] base, input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         beat(base + 8'(i), tag_of(i));
         if (i != last) repeat (gap) tick();
      end
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int d0;
      reset            = 1'b0;
      run_capture      = 1'b0;
      display_valid_i  = 1'b0;
      display_result_i = 8'd0;
      state_display_i  = 3'd0;
      tick();
      tick();
      check("rst_state", 96'(capture_state_o), 96'(S_IDLE));
      check("rst_done", 96'(frame_done_o), 96'd0);
      check("rst_error", 96'(error_o), 96'd0);
      check("rst_outputs", obs, '0);
      reset       = 1'b1;
      run_capture = 1'b1;

      // Contiguous frame 1..12
      d0 = done_count;
      exp_q.push_back(mk(8'd1));
      send_beats(8'd1, 0, 11, 0);
      check("contig_state_done", 96'(capture_state_o), 96'(S_DONE));
      tick();
      check("contig_done_one_cycle", 96'(frame_done_o), 96'd0);
      check("contig_state_idle", 96'(capture_state_o), 96'(S_IDLE));
      check("contig_done_count", 96'(done_count - d0), 96'd1);
      check("contig_error", 96'(error_o), 96'd0);

      // Gapped frame: nothing visible until the 12th beat
      reset_dut();
      d0 = done_count;
      exp_q.push_back(mk(8'd1));
      send_beats(8'd1, 0, 10, 3);
      repeat (3) tick();
      check("gap_partial_hidden", obs, '0);
      check("gap_state_2x2", 96'(capture_state_o), 96'(S_2X2));
      send_beats(8'd1, 11, 11, 0);
      check("gap_done_count", 96'(done_count - d0), 96'd1);

      // Back-to-back frames, second starts in S_DONE
      d0 = done_count;
      exp_q.push_back(mk(8'd1));
      exp_q.push_back(mk(8'd21));
      send_beats(8'd1, 0, 11, 0);
      send_beats(8'd21, 0, 11, 0);
      tick();
      check("b2b_done_count", 96'(done_count - d0), 96'd2);
      check("b2b_outputs", obs, mk(8'd21));

      // Reset mid-frame
      send_beats(8'd60, 0, 5, 0);
      reset_dut();
      check("midrst_outputs", obs, '0);
      check("midrst_state", 96'(capture_state_o), 96'(S_IDLE));
      exp_q.push_back(mk(8'd40));
      send_beats(8'd40, 0, 11, 0);
      tick();

      // run_capture abort mid-frame
      send_beats(8'd70, 0, 6, 0);
      run_capture = 1'b0;
      tick();
      run_capture = 1'b1;
      check("abort_state", 96'(capture_state_o), 96'(S_IDLE));
      check("abort_error", 96'(error_o), 96'd0);
      check("abort_outputs_kept", obs, mk(8'd40));
      d0 = done_count;
      exp_q.push_back(mk(8'd80));
      send_beats(8'd80, 0, 11, 0);
      tick();
      check("abort_done_count", 96'(done_count - d0), 96'd1);
      check("abort_new_error", 96'(error_o), 96'd0);

      // Wrong tag on the 5th beat
      d0 = done_count;
      send_beats(8'd100, 0, 3, 0);
      beat(8'hEE, TAG_2X2);
      check("mis_error", 96'(error_o), 96'(ERR_EXP));
      check("mis_outputs_kept", obs, mk(8'd80));
`ifdef DISPLAY_CAPTURE_ERR_EN
      check("mis_state", 96'(capture_state_o), 96'(S_IDLE));
      repeat (3) tick();
      check("mis_error_sticky", 96'(error_o), 96'd1);
      check("mis_no_done", 96'(done_count - d0), 96'd0);
`else
      check("mis_state", 96'(capture_state_o), 96'(S_3X3));
      exp_q.push_back(mk(8'd100));
      send_beats(8'd100, 4, 11, 0);
      tick();
      check("mis_resume_done", 96'(done_count - d0), 96'd1);
`endif
      exp_q.push_back(mk(8'd110));
      send_beats(8'd110, 0, 11, 0);
      tick();
      check("mis_after_error", 96'(error_o), 96'(ERR_EXP));

      // Non-PE tag in idle never starts a frame
      reset_dut();
      check("reset_clears_error", 96'(error_o), 96'd0);
      beat(8'h55, TAG_3X3);
      check("idle_mis_state", 96'(capture_state_o), 96'(S_IDLE));
      check("idle_mis_error", 96'(error_o), 96'(ERR_EXP));
      exp_q.push_back(mk(8'd120));
      send_beats(8'd120, 0, 11, 0);
      tick();
      check("scoreboard_empty", 96'(exp_q.size()), 96'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
